imem_fetch_rom: RTL and testbench
=================================

# imem_fetch_rom

Parametrised, byte-addressed, big-endian instruction ROM with a registered read path and a valid/ready request/response handshake. It is the next-generation fetch memory for the PA-RISC datapath, replacing the purely combinational instruction ROM. It sits between the PC/fetch stage and the IF/ID pipeline register. It supports configurable word width, depth and read wait states, and it flags out-of-range (and optionally misaligned) fetches.

## Interface
- `ADDR_WIDTH`, 9: width of the byte address.
- `DATA_WIDTH`, 32: fetch word width in bits; must be a multiple of 8. `BYTES = DATA_WIDTH/8`.
- `DEPTH_BYTES`, 512: number of byte locations in `Mem`; must be ≤ 2^ADDR_WIDTH.
- `WAIT_STATES`, 0: extra cycles before a response is presented (0–15).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_addr`  in  ADDR_WIDTH  byte address of the fetch.
- `rsp_valid`  out  1  response data and error flag are valid.
- `rsp_ready`  in  1  consumer accepts the response this cycle.
- `rsp_data`  out  DATA_WIDTH  fetched word, big-endian.
- `rsp_err`  out  1  fetch faulted (out of range, or misaligned when the trap is enabled).
- Storage is `reg [7:0] Mem [0:DEPTH_BYTES-1]`. Benches preload it hierarchically with `$readmemb`, one byte per line. `Mem` is never reset or written by the block.

## Operation
- Word assembly: `rsp_data = {Mem[a], Mem[a+1], …, Mem[a+BYTES-1]}`, where `a` is the effective address. Lowest address goes in the MSB byte.
- Range check: if `a + BYTES - 1 ≥ DEPTH_BYTES`:
  - `rsp_err = 1`, `rsp_data = 0`.
  - No wrap-around.
- The request is captured on acceptance (`req_valid && req_ready` at an edge). Later changes to `req_addr` have no effect on that request.
- FSM states:
  - `IDLE`: `req_ready = 1`. On acceptance, go to `WAIT` if `WAIT_STATES > 0`, else to `RESP`.
  - `WAIT`: `req_ready = 0`. The counter is loaded with `WAIT_STATES-1` on acceptance and decrements each cycle. At 0, go to `RESP`.
  - `RESP`: `rsp_valid = 1`; `req_ready = rsp_ready`.
    - `rsp_ready = 0`: hold state and all outputs stable (stall).
    - `rsp_ready = 1` with a new request: accept it (back-to-back) and go to `WAIT`/`RESP` as from `IDLE`.
    - `rsp_ready = 1` with no request: go to `IDLE`.
- Simultaneous consume + accept with `WAIT_STATES = 0`: `rsp_valid` stays high and `rsp_data` updates to the new word the next cycle. This gives one fetch per cycle.
- `rsp_data`/`rsp_err` change only when entering `RESP`.

## Timing
- Reset values: state `IDLE`, `req_ready = 1`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_err = 0`, wait counter 0.
- Reset asserted mid-`WAIT` or mid-`RESP` drops the pending request immediately, with no response. `Mem` is unaffected.
- Latency: request accepted at edge N → `rsp_valid` high after edge N+WAIT_STATES. This is 1 cycle for `WAIT_STATES = 0`.
- Throughput:
  - `WAIT_STATES = 0`: 1 word per cycle with `rsp_ready` held high.
  - Otherwise: 1 word per `WAIT_STATES+1` cycles.
- `req_ready` is combinational from state and `rsp_ready` only. There is no path from `req_valid` to `req_ready`.

## Configuration
- `IMEM_MISALIGN_TRAP_EN` defined:
  - A request with `req_addr % BYTES ≠ 0` responds with `rsp_err = 1`, `rsp_data = 0`, after normal latency.
  - The effective address equals `req_addr`.
- `IMEM_MISALIGN_TRAP_EN` undefined:
  - The low `log2(BYTES)` address bits are forced to 0 (word-aligned fetch).
  - Misalignment never raises `rsp_err`; only the range check applies.

## Test plan
- Preload `Mem[0..7] = E8,1F,1F,DD,08,00,02,40`, default parameters. Request addr 0, then addr 4, `rsp_ready = 1` throughout → `32'hE81F1FDD` then `32'h08000240` on consecutive cycles; `rsp_err = 0`.
- Stall: request addr 4 with `rsp_ready = 0` for 3 cycles → `rsp_valid`/`rsp_data = 32'h08000240` held stable, `req_ready = 0`. Raise `rsp_ready` → response consumed, state returns to `IDLE`.
- `WAIT_STATES = 3`: request addr 0 at edge N → `rsp_valid` first high after edge N+3 with `32'hE81F1FDD`; `req_ready = 0` during `WAIT`.
- Out of range: request addr 510, `DEPTH_BYTES = 512` → `rsp_err = 1`, `rsp_data = 0`. Request addr 508 → `rsp_err = 0`.
- Misaligned addr 2:
  - With `IMEM_MISALIGN_TRAP_EN`: `rsp_err = 1`, `rsp_data = 0`.
  - Without it: `rsp_data = 32'hE81F1FDD`, `rsp_err = 0`.
- Assert `reset` during `WAIT` (`WAIT_STATES = 3`) → `rsp_valid` stays 0 and `req_ready = 1` immediately. Next request addr 4 returns `32'h08000240` normally.

Source files
------------

// File: rtl/imem_fetch_rom.sv
// imem_fetch_rom: byte-addressed, big-endian instruction ROM with a registered, valid/ready read path.
// Optional misaligned-fetch trap is enabled by defining IMEM_MISALIGN_TRAP_EN.
module imem_fetch_rom #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int EXT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    reg [7:0] Mem [0:DEPTH_BYTES-1];

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    load;
    logic [ADDR_WIDTH-1:0]   fetch_addr;
    logic [ADDR_WIDTH-1:0]   eff_addr;
    logic                    fetch_err;
    logic [DATA_WIDTH-1:0]   fetch_word;

    // A word is read either straight from the accepting request or from the captured address after waiting.
    always_comb begin
        fetch_addr = (state_q == WAIT) ? addr_q : req_addr;
`ifdef IMEM_MISALIGN_TRAP_EN
        eff_addr   = fetch_addr;
        fetch_err  = (({1'b0, eff_addr} + EXT_W'(BYTES - 1)) >= EXT_W'(DEPTH_BYTES))
                     || (|(fetch_addr & OFF_MASK));
`else
        eff_addr   = fetch_addr & ~OFF_MASK;
        fetch_err  = ({1'b0, eff_addr} + EXT_W'(BYTES - 1)) >= EXT_W'(DEPTH_BYTES);
`endif
    end

    // Lowest address lands in the most significant byte; faulted fetches return zero.
    always_comb begin
        fetch_word = '0;
        if (!fetch_err) begin
            for (int i = 0; i < BYTES; i++) begin
                fetch_word[DATA_WIDTH-1-8*i -: 8] = Mem[IDX_W'({1'b0, eff_addr} + EXT_W'(i))];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        load      = 1'b0;
        req_ready = 1'b0;

        case (state_q)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = rsp_ready;
            default: req_ready = 1'b0;
        endcase

        accept = req_valid && req_ready;

        if (accept) begin
            addr_d = req_addr;
            if (WAIT_STATES > 0) begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = RESP;
                load    = 1'b1;
            end
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = RESP;
                        load    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Response registers change only on entry to RESP, so a stall holds them stable.
        if (load) begin
            data_d = fetch_word;
            err_d  = fetch_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_rom.sv
// Bench for imem_fetch_rom: one instance with no wait states, one with three, directed steps then random traffic.
// Expectations come from a byte-array ROM model and a transaction-level latency model.
module tb_imem_fetch_rom;
    logic        clk;
    logic        rst [2];
    logic        v   [2];
    logic        r   [2];
    logic [8:0]  a   [2];
    logic        rdy [2];
    logic        vld [2];
    logic [31:0] dat [2];
    logic        err [2];

    logic [7:0]  ref_mem [0:511];
    int          total = 0;
    int          bad   = 0;

`ifdef IMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    imem_fetch_rom #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH_BYTES(512), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(v[0]), .req_ready(rdy[0]), .req_addr(a[0]),
        .rsp_valid(vld[0]), .rsp_ready(r[0]), .rsp_data(dat[0]), .rsp_err(err[0])
    );

    imem_fetch_rom #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH_BYTES(512), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(rst[1]), .req_valid(v[1]), .req_ready(rdy[1]), .req_addr(a[1]),
        .rsp_valid(vld[1]), .rsp_ready(r[1]), .rsp_data(dat[1]), .rsp_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_fetch(input int addr);
        int ea;
        ea = addr;
        if (addr % 4 != 0) begin
            if (TRAP) return {1'b1, 32'h0};
            ea = addr - (addr % 4);
        end
        if (ea + 3 >= 512) return {1'b1, 32'h0};
        return {1'b0, ref_mem[ea], ref_mem[ea+1], ref_mem[ea+2], ref_mem[ea+3]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Request one word from an idle instance and check latency, payload and return to idle.
    task automatic fetch_chk(input int k, input int addr, input string tag);
        int lat;
        logic [32:0] ex;
        lat = 0;
        ex = ref_fetch(addr);
        v[k] = 1'b1; a[k] = 9'(addr); r[k] = 1'b1;
        cyc();
        v[k] = 1'b0; a[k] = ~a[k];
        #1;
        while (vld[k] !== 1'b1 && lat < 20) begin
            chk({tag, "_wait_ready"}, rdy[k], 0);
            cyc(); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, (k == 1) ? 3 : 0);
        chk({tag, "_data"}, dat[k], ex[31:0]);
        chk({tag, "_err"}, err[k], ex[32]);
        cyc(); #1;
        chk({tag, "_idle_valid"}, vld[k], 0);
        chk({tag, "_idle_ready"}, rdy[k], 1);
    endtask

    // Random traffic against a one-outstanding-request model: response due ws edges after acceptance.
    task automatic rand_run(input int k, input int ws, input int n);
        bit busy, acc_p, con_p, ev, er;
        int e, due;
        logic [8:0] cur, addr_p;
        logic [32:0] ex;
        busy = 0; acc_p = 0; con_p = 0; e = 0; due = 0; cur = '0; addr_p = '0;
        for (int c = 0; c < n; c++) begin
            cyc();
            e++;
            if (con_p) busy = 0;
            if (acc_p) begin
                busy = 1;
                cur  = addr_p;
                due  = e + ws;
            end
            v[k] = ($urandom_range(0, 3) != 0);
            a[k] = 9'($urandom_range(0, 511));
            r[k] = ($urandom_range(0, 3) != 0);
            #1;
            ev = busy && (e >= due);
            er = !busy || (ev && r[k]);
            chk("rnd_req_ready", rdy[k], er);
            chk("rnd_rsp_valid", vld[k], ev);
            if (ev) begin
                ex = ref_fetch(cur);
                chk("rnd_rsp_data", dat[k], ex[31:0]);
                chk("rnd_rsp_err", err[k], ex[32]);
            end
            acc_p  = v[k] && er;
            con_p  = ev && r[k];
            addr_p = a[k];
        end
        v[k] = 1'b0;
        r[k] = 1'b1;
    endtask

    initial begin
        logic [31:0] pre;
        pre = 32'hE81F1FDD;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) ref_mem[i] = pre[31-8*i -: 8];
        pre = 32'h08000240;
        for (int i = 0; i < 4; i++) ref_mem[4+i] = pre[31-8*i -: 8];
        pre = 32'h11223344;
        for (int i = 0; i < 4; i++) ref_mem[508+i] = pre[31-8*i -: 8];
        for (int i = 0; i < 512; i++) begin
            dut0.Mem[i] = ref_mem[i];
            dut3.Mem[i] = ref_mem[i];
        end

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; v[k] = 1'b0; r[k] = 1'b0; a[k] = '0;
        end
        cyc(); cyc();
        for (int k = 0; k < 2; k++) begin
            chk("reset_req_ready", rdy[k], 1);
            chk("reset_rsp_valid", vld[k], 0);
            chk("reset_rsp_data", dat[k], 0);
            chk("reset_rsp_err", err[k], 0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        cyc();

        // back-to-back fetches at one word per cycle
        v[0] = 1'b1; a[0] = 9'd0; r[0] = 1'b1;
        cyc();
        a[0] = 9'd4;
        #1;
        chk("b2b_first_valid", vld[0], 1);
        chk("b2b_first_data", dat[0], 32'hE81F1FDD);
        chk("b2b_first_err", err[0], 0);
        chk("b2b_first_ready", rdy[0], 1);
        cyc();
        v[0] = 1'b0; a[0] = 9'd0;
        #1;
        chk("b2b_second_valid", vld[0], 1);
        chk("b2b_second_data", dat[0], 32'h08000240);
        cyc(); #1;
        chk("b2b_drain_valid", vld[0], 0);

        // stall with rsp_ready low, address changed after capture
        v[0] = 1'b1; a[0] = 9'd4; r[0] = 1'b0;
        cyc();
        v[0] = 1'b0; a[0] = 9'd0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_valid", vld[0], 1);
            chk("stall_data", dat[0], 32'h08000240);
            chk("stall_ready", rdy[0], 0);
            cyc();
        end
        r[0] = 1'b1;
        #1;
        chk("stall_release_ready", rdy[0], 1);
        cyc(); #1;
        chk("stall_consumed_valid", vld[0], 0);

        fetch_chk(0, 510, "range_510");
        fetch_chk(0, 508, "range_508");
        fetch_chk(0, 511, "range_511");
        fetch_chk(0, 2, "misalign_2");
        fetch_chk(0, 7, "misalign_7");

        // wait-state instance
        fetch_chk(1, 0, "ws3_addr0");
        fetch_chk(1, 510, "ws3_range");

        // reset in the middle of WAIT drops the request
        v[1] = 1'b1; a[1] = 9'd0; r[1] = 1'b1;
        cyc();
        v[1] = 1'b0;
        cyc();
        rst[1] = 1'b1;
        #1;
        chk("rst_wait_valid", vld[1], 0);
        chk("rst_wait_ready", rdy[1], 1);
        cyc();
        rst[1] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cyc(); #1;
            chk("rst_wait_no_rsp", vld[1], 0);
        end
        fetch_chk(1, 4, "post_reset_addr4");

        rand_run(0, 0, 400);
        rand_run(1, 3, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
